dlsc_pcie_s6_inbound_read_split: RTL and testbench
==================================================

Name: dlsc_pcie_s6_inbound_read_split

Overview:
- Completer-side splitter for inbound memory read requests.
- Accepts one request header at a time and emits a sequence of completion headers (CplD) that obey Max_Payload_Size and the Read Completion Boundary.
- Computes per-completion length, address, Byte Count and Lower Address.
- Sits between the inbound TLP decoder and the completion data mover / TX arbiter.

Parameters:
- ADDR, 32, request address width (bits ADDR-1:2 carried)
- MPS_MAX, 2, largest supported Max_Payload_Size encoding (0=128B … 5=4096B)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_h_ready  out  1  request header accept
- req_h_valid  in  1  request header valid
- req_h_addr  in  ADDR-2  dword address [ADDR-1:2]
- req_h_len  in  10  length in dwords (0 = 1024)
- req_h_tag  in  8  requester tag
- req_h_reqid  in  16  requester ID
- req_h_be_first  in  4  first-DW byte enables
- req_h_be_last  in  4  last-DW byte enables (0 when len==1)
- req_h_err  in  1  request unsupported (see Optional Feature)
- cpl_h_ready  in  1  completion header accept
- cpl_h_valid  out  1  completion header valid
- cpl_h_addr  out  ADDR-2  dword address of this completion's payload
- cpl_h_len  out  10  payload dwords (0 = 1024)
- cpl_h_tag  out  8  copied from request
- cpl_h_reqid  out  16  copied from request
- cpl_h_lower_addr  out  7  Lower Address field
- cpl_h_byte_count  out  12  remaining bytes including this completion (4096 encoded as 0)
- cpl_h_status  out  3  completion status
- cpl_h_last  out  1  final completion of request
- max_payload_size  in  3  config MPS encoding
- rcb  in  1  0 = 64B RCB, 1 = 128B RCB

Behaviour:
- Reset (async assert, sync deassert) puts the FSM in IDLE.
  - Reset values: cpl_h_valid=0, req_h_ready=1, all other outputs 0.
- FSM states: IDLE, CALC, SEND.
  - IDLE: req_h_ready=1. On req_h_valid, latch the request and go to CALC. req_h_ready=0 outside IDLE.
  - CALC (one cycle): compute the next chunk, then go to SEND.
  - SEND: cpl_h_valid=1. All cpl_h_* fields are held stable until cpl_h_ready.
    - On accept: if last, go to IDLE (cpl_h_valid drops the next cycle); else update state and go to CALC.
- Latency: first cpl_h_valid appears 2 cycles after request accept. Minimum spacing between completions is 2 cycles.
- rem_dw is 11 bits; len 0 is treated as 1024.
- Chunk length:
  - mps_eff = min(max_payload_size, MPS_MAX); max_dw = 32 << mps_eff.
  - off = addr[5:2] when rcb=0, addr[6:2] when rcb=1.
  - chunk = min(rem_dw, max_dw − off).
  - Effect: every non-final completion ends on an RCB boundary.
- After each accepted completion: addr += chunk, rem_dw −= chunk. last = (chunk == rem_dw).
- Byte count initial value:
  - lead = count of leading zero bits of be_first (from bit 0); trail = count of leading zero bits of be_last from bit 3.
  - len>1: bc = len·4 − lead − trail.
  - len==1: bc = span from lowest to highest set bit of be_first.
  - len==1 with be_first==0: bc = 1 (zero-length read).
- Byte count update: after each completion, bc −= chunk·4 − (first ? lead : 0).
- Lower address: {addr[6:2], lead[1:0]} on the first completion, {addr[6:2], 2'b00} on subsequent ones. For a zero-length read, lower 2 bits are 0.
- Status: cpl_h_status = 3'b000 (SC).
- A new request cannot be accepted while any completion of the current one is outstanding.

Optional Feature:
- Macro: DLSC_PCIE_S6_INBOUND_READ_UR_EN
- Defined:
  - A request with req_h_err=1 produces exactly one completion: status 3'b001 (UR), len 0, byte_count 4, lower_addr 0, last=1.
  - Semantically this is a Cpl without data; downstream logic keys on status≠0.
- Undefined:
  - req_h_err is ignored and status is always SC.

Test Plan:
- Split across RCB/MPS: MPS=0 (128B), rcb=0, addr=0x1010, len=64, be F/F → three completions.
  - addr/len/bc/la = 0x1010/28/256/0x10, then 0x1080/32/144/0x00, then 0x1100/4/16/0x00.
  - last asserted only on the third.
- Single DW: len=1, be_first=4'b0110, addr=0x2000 → one completion: len=1, bc=2, la=0x01, last=1.
- Zero-length read: len=1, be_first=0 → bc=1, la=0x00, len=1.
- Max length: len=0, MPS=2 (512B) with MPS_MAX≥2, addr=0 → eight 128-DW completions.
  - First bc=0 (4096); subsequent bc=3584, 3072 … 512.
- Backpressure and reset: hold cpl_h_ready=0 for 10 cycles → all fields stable. Then pulse rst_n low mid-SEND → cpl_h_valid=0 immediately and req_h_ready=1 after release.
- UR path (macro defined): req_h_err=1, len=16 → single completion: status=001, len=0, bc=4, last=1.

Source files
------------

// File: rtl/dlsc_pcie_s6_inbound_read_split.sv
`default_nettype none
// ============================================================================
// Module   : dlsc_pcie_s6_inbound_read_split
// Function : Splits one inbound memory read request into CplD headers that
//            respect Max_Payload_Size and the Read Completion Boundary.
//            Optional: DLSC_PCIE_S6_INBOUND_READ_UR_EN (UR completion on err).
// Revision : 1.0 - initial release
// ============================================================================
module dlsc_pcie_s6_inbound_read_split #(
   parameter int ADDR    = 32,
   parameter int MPS_MAX = 2
) (
   input  logic            clk,
   input  logic            rst_n,

   output logic            req_h_ready,
   input  logic            req_h_valid,
   input  logic [ADDR-3:0] req_h_addr,
   input  logic [9:0]      req_h_len,
   input  logic [7:0]      req_h_tag,
   input  logic [15:0]     req_h_reqid,
   input  logic [3:0]      req_h_be_first,
   input  logic [3:0]      req_h_be_last,
   input  logic            req_h_err,

   input  logic            cpl_h_ready,
   output logic            cpl_h_valid,
   output logic [ADDR-3:0] cpl_h_addr,
   output logic [9:0]      cpl_h_len,
   output logic [7:0]      cpl_h_tag,
   output logic [15:0]     cpl_h_reqid,
   output logic [6:0]      cpl_h_lower_addr,
   output logic [11:0]     cpl_h_byte_count,
   output logic [2:0]      cpl_h_status,
   output logic            cpl_h_last,

   input  logic [2:0]      max_payload_size,
   input  logic            rcb
);

   localparam logic [2:0] C_MPS_MAX   = 3'(MPS_MAX);
   localparam logic [2:0] C_STATUS_SC = 3'b000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_SEND = 2'd2
   } state_t;

   state_t r_state, w_state_next;

   // Zero bits below the lowest enabled byte.
   function automatic logic [1:0] f_lead(input logic [3:0] be);
      casez (be)
         4'b???1: f_lead = 2'd0;
         4'b??10: f_lead = 2'd1;
         4'b?100: f_lead = 2'd2;
         4'b1000: f_lead = 2'd3;
         default: f_lead = 2'd0;
      endcase
   endfunction

   // Zero bits above the highest enabled byte.
   function automatic logic [1:0] f_trail(input logic [3:0] be);
      casez (be)
         4'b1???: f_trail = 2'd0;
         4'b01??: f_trail = 2'd1;
         4'b001?: f_trail = 2'd2;
         4'b0001: f_trail = 2'd3;
         default: f_trail = 2'd0;
      endcase
   endfunction

   logic [ADDR-3:0] r_addr;
   logic [10:0]     r_rem;
   logic [12:0]     r_bc;
   logic [1:0]      r_lead;
   logic            r_first;
   logic [10:0]     r_chunk;
   logic [7:0]      r_tag;
   logic [15:0]     r_reqid;
   logic [9:0]      r_cpl_len;
   logic [11:0]     r_cpl_bc;
   logic [6:0]      r_cpl_la;
   logic            r_cpl_last;
   logic [2:0]      r_cpl_status;
`ifdef DLSC_PCIE_S6_INBOUND_READ_UR_EN
   logic            r_err;
`else
   logic            w_unused_err;
   assign w_unused_err = req_h_err;
`endif

   // ---- request-side initial values ----
   logic [10:0] w_req_rem;
   logic [1:0]  w_req_lead;
   logic [12:0] w_req_bc;

   always_comb begin
      w_req_rem  = (req_h_len == 10'd0) ? 11'd1024 : {1'b0, req_h_len};
      w_req_lead = f_lead(req_h_be_first);
      w_req_bc   = 13'd0;
      if (w_req_rem == 11'd1) begin
         // Single DW: span from lowest to highest enabled byte; 1 for zero-length.
         if (req_h_be_first == 4'd0)
            w_req_bc = 13'd1;
         else
            w_req_bc = 13'd4 - {11'd0, w_req_lead} - {11'd0, f_trail(req_h_be_first)};
      end else begin
         w_req_bc = {w_req_rem, 2'b00} - {11'd0, w_req_lead} - {11'd0, f_trail(req_h_be_last)};
      end
   end

   // ---- chunk sizing: stop at the next RCB boundary inside the MPS window ----
   logic [2:0]  w_mps_eff;
   logic [10:0] w_max_dw;
   logic [10:0] w_off;
   logic [10:0] w_room;
   logic [10:0] w_chunk;
   logic        w_last;
   logic [6:0]  w_la;

   always_comb begin
      w_mps_eff = (max_payload_size > C_MPS_MAX) ? C_MPS_MAX : max_payload_size;
      w_max_dw  = 11'd32 << w_mps_eff;
      w_off     = rcb ? {6'd0, r_addr[4:0]} : {7'd0, r_addr[3:0]};
      w_room    = w_max_dw - w_off;
      w_chunk   = (r_rem < w_room) ? r_rem : w_room;
      w_last    = (w_chunk == r_rem);
      w_la      = {r_addr[4:0], (r_first ? r_lead : 2'b00)};
   end

   // ---- FSM ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (req_h_valid) w_state_next = ST_CALC;
         ST_CALC: w_state_next = ST_SEND;
         ST_SEND: if (cpl_h_ready) w_state_next = r_cpl_last ? ST_IDLE : ST_CALC;
         default: w_state_next = ST_IDLE;
      endcase
   end

   assign req_h_ready = (r_state == ST_IDLE);
   assign cpl_h_valid = (r_state == ST_SEND);

   // ---- datapath ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr       <= '0;
         r_rem        <= '0;
         r_bc         <= '0;
         r_lead       <= '0;
         r_first      <= 1'b0;
         r_chunk      <= '0;
         r_tag        <= '0;
         r_reqid      <= '0;
         r_cpl_len    <= '0;
         r_cpl_bc     <= '0;
         r_cpl_la     <= '0;
         r_cpl_last   <= 1'b0;
         r_cpl_status <= '0;
`ifdef DLSC_PCIE_S6_INBOUND_READ_UR_EN
         r_err        <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_h_valid) begin
                  r_addr  <= req_h_addr;
                  r_rem   <= w_req_rem;
                  r_bc    <= w_req_bc;
                  r_lead  <= w_req_lead;
                  r_first <= 1'b1;
                  r_tag   <= req_h_tag;
                  r_reqid <= req_h_reqid;
`ifdef DLSC_PCIE_S6_INBOUND_READ_UR_EN
                  r_err   <= req_h_err;
`endif
               end
            end
            ST_CALC: begin
               r_chunk      <= w_chunk;
               r_cpl_len    <= w_chunk[9:0];
               r_cpl_bc     <= r_bc[11:0];
               r_cpl_la     <= w_la;
               r_cpl_last   <= w_last;
               r_cpl_status <= C_STATUS_SC;
`ifdef DLSC_PCIE_S6_INBOUND_READ_UR_EN
               if (r_err) begin
                  // Unsupported request: single data-less completion.
                  r_chunk      <= 11'd0;
                  r_cpl_len    <= 10'd0;
                  r_cpl_bc     <= 12'd4;
                  r_cpl_la     <= 7'd0;
                  r_cpl_last   <= 1'b1;
                  r_cpl_status <= 3'b001;
               end
`endif
            end
            ST_SEND: begin
               if (cpl_h_ready) begin
                  r_addr  <= r_addr + (ADDR-2)'(r_chunk);
                  r_rem   <= r_rem - r_chunk;
                  r_bc    <= r_bc - ({r_chunk, 2'b00} - {11'd0, (r_first ? r_lead : 2'b00)});
                  r_first <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign cpl_h_addr       = r_addr;
   assign cpl_h_len        = r_cpl_len;
   assign cpl_h_tag        = r_tag;
   assign cpl_h_reqid      = r_reqid;
   assign cpl_h_lower_addr = r_cpl_la;
   assign cpl_h_byte_count = r_cpl_bc;
   assign cpl_h_status     = r_cpl_status;
   assign cpl_h_last       = r_cpl_last;

endmodule
`default_nettype wire

// File: tb/tb_dlsc_pcie_s6_inbound_read_split.sv
`default_nettype none
// ============================================================================
// Module   : tb_dlsc_pcie_s6_inbound_read_split
// Function : Directed self-checking bench for the inbound read splitter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dlsc_pcie_s6_inbound_read_split;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_h_ready;
   logic        req_h_valid = 1'b0;
   logic [29:0] req_h_addr = '0;
   logic [9:0]  req_h_len = '0;
   logic [7:0]  req_h_tag = '0;
   logic [15:0] req_h_reqid = '0;
   logic [3:0]  req_h_be_first = '0;
   logic [3:0]  req_h_be_last = '0;
   logic        req_h_err = 1'b0;
   logic        cpl_h_ready = 1'b1;
   logic        cpl_h_valid;
   logic [29:0] cpl_h_addr;
   logic [9:0]  cpl_h_len;
   logic [7:0]  cpl_h_tag;
   logic [15:0] cpl_h_reqid;
   logic [6:0]  cpl_h_lower_addr;
   logic [11:0] cpl_h_byte_count;
   logic [2:0]  cpl_h_status;
   logic        cpl_h_last;
   logic [2:0]  max_payload_size = 3'd0;
   logic        rcb = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   dlsc_pcie_s6_inbound_read_split #(.ADDR(32), .MPS_MAX(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_h_ready(req_h_ready), .req_h_valid(req_h_valid), .req_h_addr(req_h_addr),
      .req_h_len(req_h_len), .req_h_tag(req_h_tag), .req_h_reqid(req_h_reqid),
      .req_h_be_first(req_h_be_first), .req_h_be_last(req_h_be_last), .req_h_err(req_h_err),
      .cpl_h_ready(cpl_h_ready), .cpl_h_valid(cpl_h_valid), .cpl_h_addr(cpl_h_addr),
      .cpl_h_len(cpl_h_len), .cpl_h_tag(cpl_h_tag), .cpl_h_reqid(cpl_h_reqid),
      .cpl_h_lower_addr(cpl_h_lower_addr), .cpl_h_byte_count(cpl_h_byte_count),
      .cpl_h_status(cpl_h_status), .cpl_h_last(cpl_h_last),
      .max_payload_size(max_payload_size), .rcb(rcb)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Present one request (byte address) and let it be accepted.
   task automatic send_req(input logic [31:0] baddr, input logic [9:0] len,
                           input logic [3:0] bef, input logic [3:0] bel);
      @(negedge clk);
      check("req_ready_idle", {31'd0, req_h_ready}, 32'd1);
      req_h_valid    = 1'b1;
      req_h_addr     = baddr[31:2];
      req_h_len      = len;
      req_h_tag      = 8'h5A;
      req_h_reqid    = 16'hBEEF;
      req_h_be_first = bef;
      req_h_be_last  = bel;
      @(posedge clk);
      #1 req_h_valid = 1'b0;
   endtask

   // Wait for a completion, check it, let it be accepted (cpl_h_ready=1).
   task automatic expect_cpl(input string tag, input bit first, input logic [31:0] baddr,
                             input int len, input int bc, input int la, input bit last);
      int waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!cpl_h_valid && waited < 20);
      if (!cpl_h_valid) begin
         check({tag, "_timeout"}, 32'd0, 32'd1);
      end else begin
         if (first) check({tag, "_latency"}, waited, 2);
         check({tag, "_addr"}, {cpl_h_addr, 2'b00}, baddr);
         check({tag, "_len"},  {22'd0, cpl_h_len}, len);
         check({tag, "_bc"},   {20'd0, cpl_h_byte_count}, bc);
         check({tag, "_la"},   {25'd0, cpl_h_lower_addr}, la);
         check({tag, "_last"}, {31'd0, cpl_h_last}, {31'd0, last});
         check({tag, "_stat"}, {29'd0, cpl_h_status}, 32'd0);
         check({tag, "_tag"},  {8'd0, cpl_h_reqid, cpl_h_tag}, 32'h00BEEF5A);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      // Reset state
      #12;
      @(negedge clk);
      check("rst_valid", {31'd0, cpl_h_valid}, 32'd0);
      check("rst_ready", {31'd0, req_h_ready}, 32'd1);
      check("rst_len",   {22'd0, cpl_h_len}, 32'd0);
      check("rst_bc",    {20'd0, cpl_h_byte_count}, 32'd0);
      check("rst_last",  {31'd0, cpl_h_last}, 32'd0);
      rst_n = 1'b1;

      // Split across RCB/MPS: 128B MPS, 64B RCB
      max_payload_size = 3'd0; rcb = 1'b0;
      send_req(32'h1010, 10'd64, 4'hF, 4'hF);
      expect_cpl("s1a", 1, 32'h1010, 28, 256, 8'h10, 0);
      expect_cpl("s1b", 0, 32'h1080, 32, 144, 8'h00, 0);
      expect_cpl("s1c", 0, 32'h1100,  4,  16, 8'h00, 1);

      // Single DW with partial byte enables
      send_req(32'h2000, 10'd1, 4'b0110, 4'b0000);
      expect_cpl("sdw", 1, 32'h2000, 1, 2, 8'h01, 1);

      // Zero-length read
      send_req(32'h3000, 10'd1, 4'b0000, 4'b0000);
      expect_cpl("zlr", 1, 32'h3000, 1, 1, 8'h00, 1);

      // 128B RCB: first chunk stops at 0x80, lead/trail both 2
      rcb = 1'b1;
      send_req(32'h0040, 10'd40, 4'b1100, 4'b0011);
      expect_cpl("rcba", 1, 32'h0040, 16, 156, 8'h42, 0);
      expect_cpl("rcbb", 0, 32'h0080, 24,  94, 8'h00, 1);
      rcb = 1'b0;

      // Max length, 512B MPS: eight 128-DW completions
      max_payload_size = 3'd2;
      send_req(32'h0000, 10'd0, 4'hF, 4'hF);
      for (int i = 0; i < 8; i++)
         expect_cpl($sformatf("max%0d", i), (i == 0), 32'(i * 512), 128,
                    (4096 - i * 512) % 4096, 0, (i == 7));

      // MPS beyond MPS_MAX clamps to 512B
      max_payload_size = 3'd5;
      send_req(32'h0000, 10'd200, 4'hF, 4'hF);
      expect_cpl("clpa", 1, 32'h0000, 128, 800, 0, 0);
      expect_cpl("clpb", 0, 32'h0200,  72, 288, 0, 1);

      // Backpressure: fields held while cpl_h_ready low
      max_payload_size = 3'd0;
      cpl_h_ready = 1'b0;
      send_req(32'h4000, 10'd8, 4'hF, 4'hF);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            check("bp_valid", {31'd0, cpl_h_valid}, 32'd1);
            check("bp_addr",  {cpl_h_addr, 2'b00}, 32'h4000);
            check("bp_len",   {22'd0, cpl_h_len}, 32'd8);
            check("bp_bc",    {20'd0, cpl_h_byte_count}, 32'd32);
            check("bp_last",  {31'd0, cpl_h_last}, 32'd1);
         end
      end
      check("bp_ready_busy", {31'd0, req_h_ready}, 32'd0);

      // Asynchronous reset mid-SEND
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", {31'd0, cpl_h_valid}, 32'd0);
      check("arst_ready", {31'd0, req_h_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      cpl_h_ready = 1'b1;
      @(negedge clk);
      check("post_ready", {31'd0, req_h_ready}, 32'd1);
      check("post_valid", {31'd0, cpl_h_valid}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
